// File: rtl/crc_serial_enc.sv
// Serial CRC encoder: forwards MSG_LEN message bits MSB-first, then appends the
// CRC_W-bit remainder MSB-first. All codeword outputs are registered.
module crc_serial_enc #(
    parameter int MSG_LEN = 8,
    parameter int CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY = 8'h07,
    parameter logic [CRC_W-1:0] INIT = '0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_data,
    input  logic i_data_valid,
    output logic o_data_ready,
    output logic o_code,
    output logic o_code_valid,
    output logic o_crc_flag,
    output logic o_done,
    output logic o_busy
);

    localparam int CNT_W = $clog2(MSG_LEN + CRC_W + 1);
    localparam logic [CNT_W-1:0] LAST_MSG = CNT_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CRC = CNT_W'(CRC_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CRC_W-1:0] crc_reg, crc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             code_reg, code_next;
    logic             code_valid_reg, code_valid_next;
    logic             crc_flag_reg, crc_flag_next;
    logic             done_reg, done_next;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg      <= S_IDLE;
            crc_reg        <= '0;
            cnt_reg        <= '0;
            code_reg       <= 1'b0;
            code_valid_reg <= 1'b0;
            crc_flag_reg   <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            crc_reg        <= crc_next;
            cnt_reg        <= cnt_next;
            code_reg       <= code_next;
            code_valid_reg <= code_valid_next;
            crc_flag_reg   <= crc_flag_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        logic fb;
        fb              = 1'b0;
        state_next      = state_reg;
        crc_next        = crc_reg;
        cnt_next        = cnt_reg;
        code_next       = 1'b0;
        code_valid_next = 1'b0;
        crc_flag_next   = 1'b0;
        done_next       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    state_next = S_DATA;
                    crc_next   = INIT;
                    cnt_next   = '0;
                end
            end
            S_DATA: begin
                // Without a valid bit the frame simply waits; nothing advances.
                if (i_data_valid) begin
                    fb              = i_data ^ crc_reg[CRC_W-1];
                    crc_next        = {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
                    code_next       = i_data;
                    code_valid_next = 1'b1;
                    if (cnt_reg == LAST_MSG) begin
                        state_next = S_CRC;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            S_CRC: begin
                code_next       = crc_reg[CRC_W-1];
                code_valid_next = 1'b1;
                crc_flag_next   = 1'b1;
                crc_next        = {crc_reg[CRC_W-2:0], 1'b0};
                if (cnt_reg == LAST_CRC) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_data_ready = (state_reg == S_DATA);
    assign o_busy       = (state_reg != S_IDLE);
    assign o_code       = code_reg;
    assign o_code_valid = code_valid_reg;
    assign o_crc_flag   = crc_flag_reg;
    assign o_done       = done_reg;

endmodule

// File: tb/tb_crc_serial_enc.sv
// Bench for crc_serial_enc: a polynomial-division model schedules every expected
// codeword bit at its cycle; one process compares the DUT outputs each cycle.
module tb_crc_serial_enc;

    logic clk = 1'b0;
    logic rst_n;
    logic start [2];
    logic din   [2];
    logic din_v [2];
    logic rdy   [2];
    logic code  [2];
    logic cv    [2];
    logic cf    [2];
    logic dn    [2];
    logic busy  [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic b;
        logic f;
        logic d;
        int   c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] cap_crc [2];
    int          cap_n   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_serial_enc u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_data(din[0]),
        .i_data_valid(din_v[0]), .o_data_ready(rdy[0]), .o_code(code[0]),
        .o_code_valid(cv[0]), .o_crc_flag(cf[0]), .o_done(dn[0]), .o_busy(busy[0])
    );

    crc_serial_enc #(.MSG_LEN(3), .CRC_W(4), .POLY(4'h3), .INIT(4'h0)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_data(din[1]),
        .i_data_valid(din_v[1]), .o_data_ready(rdy[1]), .o_code(code[1]),
        .o_code_valid(cv[1]), .o_crc_flag(cf[1]), .o_done(dn[1]), .o_busy(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // CRC as the remainder of (M(x)*x^w + INIT*x^len) divided by the full generator.
    function automatic logic [31:0] crc_calc(input logic [63:0] msg, input int len,
                                             input int w, input logic [31:0] poly,
                                             input logic [31:0] init);
        logic [127:0] v;
        logic [127:0] g;
        v = ({64'b0, msg} << w) ^ ({96'b0, init} << len);
        g = {96'b0, poly} | (128'b1 << w);
        for (int i = len + w - 1; i >= w; i--)
            if (v[i]) v = v ^ (g << (i - w));
        return v[31:0] & ((32'b1 << w) - 32'b1);
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(input int u);
        return (u == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int u);
        if (u == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic qpush(input int u, input exp_t e);
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                exp_t e;
                if (cv[u]) begin
                    if (qsize(u) == 0) begin
                        chk1("unexpected_valid", cv[u], 1'b0);
                    end else begin
                        e = qfront(u);
                        qpop(u);
                        chk1("code_bit", code[u], e.b);
                        chk1("crc_flag", cf[u], e.f);
                        chk1("done", dn[u], e.d);
                        chk("out_cycle", cyc, e.c);
                        if (cf[u]) cap_crc[u] = {cap_crc[u][30:0], code[u]};
                        cap_n[u]++;
                    end
                end else begin
                    chk1("done_without_valid", dn[u], 1'b0);
                    if (qsize(u) > 0) begin
                        e = qfront(u);
                        if (e.c <= cyc) begin
                            chk1("missing_valid", cv[u], 1'b1);
                            qpop(u);
                        end
                    end
                end
            end
        end
    end

    // Entered and left on a negedge while the unit is idle.
    task automatic run_frame(input int u, input logic [63:0] msg, input int stall_at,
                             input int stall_len, input bit hold_start,
                             input bit v_with_start, input logic [31:0] lit_crc);
        int len, w, n, n0;
        logic [31:0] poly, crc, mask;
        exp_t e;
        len  = (u == 0) ? 8 : 3;
        w    = (u == 0) ? 8 : 4;
        poly = (u == 0) ? 32'h07 : 32'h3;
        mask = (32'b1 << w) - 32'b1;
        crc  = crc_calc(msg, len, w, poly, 32'h0);
        chk("model_crc", crc, lit_crc);
        n0 = cap_n[u];
        chk1("ready_idle", rdy[u], 1'b0);
        start[u] = 1'b1;
        din_v[u] = v_with_start;
        din[u]   = 1'b1;
        @(negedge clk);
        if (!hold_start) start[u] = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    din_v[u] = 1'b0;
                    chk1("ready_stall", rdy[u], 1'b1);
                    @(negedge clk);
                end
            end
            din[u]   = msg[len-1-i];
            din_v[u] = 1'b1;
            chk1("ready_data", rdy[u], 1'b1);
            e = '{b: msg[len-1-i], f: 1'b0, d: 1'b0, c: cyc + 1};
            qpush(u, e);
            @(negedge clk);
        end
        n = cyc;
        din_v[u] = 1'b0;
        for (int j = 0; j < w; j++) begin
            e = '{b: crc[w-1-j], f: 1'b1, d: (j == w - 1), c: n + 1 + j};
            qpush(u, e);
        end
        chk1("busy_crc", busy[u], 1'b1);
        chk1("ready_crc", rdy[u], 1'b0);
        while (cyc < n + w) @(negedge clk);
        chk("crc_out", cap_crc[u] & mask, lit_crc);
        chk("valid_count", cap_n[u] - n0, len + w);
        chk1("busy_after_done", busy[u], 1'b0);
        $display("frame unit=%0d msg=%0h crc=%0h valid=%0d", u, msg, cap_crc[u] & mask, cap_n[u] - n0);
    endtask

    task automatic chk_all_zero(input int u);
        chk1("rst_code", code[u], 1'b0);
        chk1("rst_code_valid", cv[u], 1'b0);
        chk1("rst_crc_flag", cf[u], 1'b0);
        chk1("rst_done", dn[u], 1'b0);
        chk1("rst_busy", busy[u], 1'b0);
        chk1("rst_ready", rdy[u], 1'b0);
    endtask

    initial begin
        logic [7:0] rmsg;
        exp_t e;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; din[u] = 1'b0; din_v[u] = 1'b0;
            cap_crc[u] = '0; cap_n[u] = 0;
        end
        repeat (3) @(negedge clk);
        chk_all_zero(0);
        chk_all_zero(1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk1("no_self_start", busy[0], 1'b0);

        // Continuous bits, then a stall mid-message
        run_frame(0, 64'h01, -1, 0, 1'b0, 1'b0, 32'h07);
        @(negedge clk);
        run_frame(0, 64'h02, 4, 3, 1'b0, 1'b0, 32'h0E);
        @(negedge clk);

        // Start held every cycle: back-to-back frames
        run_frame(0, 64'h00, -1, 0, 1'b1, 1'b0, 32'h00);
        run_frame(0, 64'hFF, -1, 0, 1'b1, 1'b0, 32'hF3);
        start[0] = 1'b0;
        @(negedge clk);

        // Valid together with start in IDLE is not a message bit
        run_frame(0, 64'h01, -1, 0, 1'b0, 1'b1, 32'h07);
        @(negedge clk);

        // Reset after four accepted bits abandons the frame
        rmsg = 8'hA5;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din[0] = rmsg[7-i];
            din_v[0] = 1'b1;
            e = '{b: rmsg[7-i], f: 1'b0, d: 1'b0, c: cyc + 1};
            qpush(0, e);
            @(negedge clk);
        end
        rst_n = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        chk_all_zero(0);
        $display("reset mid-frame checked at cycle %0d", cyc);
        rst_n = 1'b1;
        start[0] = 1'b0;
        din_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk1("idle_after_reset", busy[0], 1'b0);
        run_frame(0, 64'h01, -1, 0, 1'b0, 1'b0, 32'h07);
        @(negedge clk);

        // Small configuration: 3 message bits, x^4+x+1
        run_frame(1, 64'h5, -1, 0, 1'b0, 1'b0, 32'hF);
        repeat (4) @(negedge clk);
        chk("queues_drained", q0.size() + q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
